// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch stage and IF/ID pipeline register of the
// 5-stage RV32I core.
//
// Owns the fetch PC (PCF). Issues at most one instruction-memory request at a
// time over a req/gnt + rvalid handshake, and captures responses into IF/ID.
// Honours the hazard unit's StallF/StallD/FlushD and redirects on PCSrcE.
// Cycles without an instruction enter decode as NOP bubbles.
//
// Optional build macro: FETCH_PERF_EN builds the fetch/kill counters.
// Without it, fetch_cnt_o and kill_cnt_o are tied to zero.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   StallF, StallD, FlushD     hazard-unit controls
//   PCSrcE, PCTargetE          taken branch/jump from EX and its target
//   imem_req_o, imem_addr_o    request (level until granted) and word address
//   imem_gnt_i                 request accepted this cycle
//   imem_rvalid_i, imem_rdata_i  response valid and instruction
//   InstrD, PCD, PCPlus4D, ValidD  IF/ID register contents
//   fetch_cnt_o, kill_cnt_o    delivered / discarded instruction counters
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] kill_cnt_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetchState_t;

  fetchState_t state;
  logic [31:0] PCF;
  logic [31:0] reqPC;
  logic        kill;
  logic        holdValid;
  logic [31:0] holdInstr;
  logic [31:0] holdPC;

  logic [31:0] targetPC;
  logic [31:0] reqPCPlus4;
  logic        respIn;
  logic        accept;
  logic        fillHold;
  logic        loadHold;
  logic        loadFresh;

  // Branch targets are always word aligned; the low bits are masked off.
  assign targetPC   = PCTargetE & ~32'd3;
  assign reqPCPlus4 = reqPC + 32'd4;

  // A response only means something while a request is outstanding.
  assign respIn    = (state == WAIT) && imem_rvalid_i;
  assign accept    = respIn && !kill && !PCSrcE;
  assign fillHold  = accept && StallD;
  assign loadHold  = holdValid && !FlushD && !StallD && !PCSrcE;
  assign loadFresh = accept && !FlushD && !StallD && !holdValid;

  // Request FSM. The request outputs are registered so they stay stable
  // while waiting for the grant.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      PCF         <= RESET_PC;
      reqPC       <= RESET_PC;
      kill        <= 1'b0;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (PCSrcE) begin
            PCF <= targetPC;
          end else if (!StallF && !holdValid) begin
            state       <= REQ;
            imem_req_o  <= 1'b1;
            imem_addr_o <= PCF;
          end
        end
        REQ: begin
          if (imem_gnt_i) begin
            // Granted: the memory will answer, so a same-cycle redirect
            // has to kill that answer rather than drop the request.
            state      <= WAIT;
            imem_req_o <= 1'b0;
            reqPC      <= imem_addr_o;
            kill       <= PCSrcE;
            if (PCSrcE) PCF <= targetPC;
          end else if (PCSrcE) begin
            state      <= IDLE;
            imem_req_o <= 1'b0;
            PCF        <= targetPC;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            kill <= 1'b0;
            if (PCSrcE) begin
              PCF   <= targetPC;
              state <= IDLE;
            end else if (kill) begin
              state <= IDLE;
            end else begin
              PCF <= reqPCPlus4;
              // Chain straight into the next request when nothing is
              // parked in the hold buffer: one instruction per two cycles.
              if (!StallF && !StallD) begin
                state       <= REQ;
                imem_req_o  <= 1'b1;
                imem_addr_o <= reqPCPlus4;
              end else begin
                state <= IDLE;
              end
            end
          end else if (PCSrcE) begin
            kill <= 1'b1;
            PCF  <= targetPC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Hold-buffer occupancy and the IF/ID register.
  // Priority: FlushD > StallD > redirect > hold buffer > fresh > bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdValid <= 1'b0;
      InstrD    <= NOP_INSTR;
      PCD       <= 32'd0;
      PCPlus4D  <= 32'd0;
      ValidD    <= 1'b0;
    end else begin
      if (PCSrcE || loadHold) begin
        holdValid <= 1'b0;
      end else if (fillHold) begin
        holdValid <= 1'b1;
      end

      if (FlushD) begin
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end else if (StallD) begin
        // IF/ID holds its contents.
      end else if (loadHold) begin
        InstrD   <= holdInstr;
        PCD      <= holdPC;
        PCPlus4D <= holdPC + 32'd4;
        ValidD   <= 1'b1;
      end else if (loadFresh) begin
        InstrD   <= imem_rdata_i;
        PCD      <= reqPC;
        PCPlus4D <= reqPCPlus4;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end
    end
  end

  // NOTE: the hold payload has no reset; holdValid qualifies it, so reset
  // values would only add flop cost without changing behaviour.
  always_ff @(posedge clk) begin
    if (fillHold) begin
      holdInstr <= imem_rdata_i;
      holdPC    <= reqPC;
    end
  end

`ifdef FETCH_PERF_EN
  logic        discard;
  logic [31:0] fetchCnt;
  logic [31:0] killCnt;

  // Killed or redirected responses, plus a fresh response flushed away.
  assign discard = (respIn && (kill || PCSrcE)) ||
                   (accept && FlushD && !StallD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchCnt <= 32'd0;
      killCnt  <= 32'd0;
    end else begin
      if (loadHold || loadFresh) fetchCnt <= fetchCnt + 32'd1;
      if (discard)               killCnt  <= killCnt + 32'd1;
    end
  end

  assign fetch_cnt_o = fetchCnt;
  assign kill_cnt_o  = killCnt;
`else
  assign fetch_cnt_o = 32'd0;
  assign kill_cnt_o  = 32'd0;
`endif

endmodule
